// File: rtl/apb_mem_pkg.sv
//============================================================================
// Module   : apb_mem_pkg
// Summary  : Shared FSM state encoding and parameter defaults for the APB
//            memory slave.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package apb_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam int c_default_data_w      = 32;
    localparam int c_default_depth       = 64;
    localparam int c_default_wait_cycles = 1;

endpackage

`default_nettype wire

// File: rtl/apb_mem_array.sv
//============================================================================
// Module   : apb_mem_array
// Summary  : Word-wide storage with one synchronous write port, an
//            asynchronous read port and an asynchronous clear.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module apb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
//============================================================================
// Module   : apb_mem_slave
// Summary  : APB slave fronting a word memory, with programmable wait
//            states and an error response for misaligned/out-of-range access.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_W      = c_default_data_w,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = c_default_depth,
    parameter int WAIT_CYCLES = c_default_wait_cycles
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    localparam int              c_idx_w    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] c_limit    = (ADDR_W+1)'(DEPTH * 4);
    localparam logic [3:0]      c_cnt_load = 4'(WAIT_CYCLES - 1);
    localparam bit              c_no_wait  = (WAIT_CYCLES == 0);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_prdata;
    logic               r_pready;
    logic               r_pslverr;

    logic [ADDR_W-1:0]  w_addr;
    logic               w_write;
    logic               w_err;
    logic               w_go_ready;
    logic               w_we;
    logic [c_idx_w-1:0] w_idx;
    logic [DATA_W-1:0]  w_rdata;

    // In IDLE the transfer is still on the bus; afterwards it lives in the latches.
    assign w_addr  = (r_state == S_IDLE) ? paddr  : r_addr;
    assign w_write = (r_state == S_IDLE) ? pwrite : r_write;
    assign w_err   = (w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= c_limit);
    assign w_idx   = w_addr[c_idx_w+1:2];

    assign w_go_ready = ((r_state == S_IDLE) && psel && !penable && c_no_wait) ||
                        ((r_state == S_WAIT) && psel && penable && (r_cnt == 4'd0));
    assign w_we       = (r_state == S_READY) && psel && r_write && !w_err;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= w_go_ready;
            r_pslverr <= w_go_ready && w_err;
            if (w_go_ready && !w_write) begin
                r_prdata <= w_err ? '0 : w_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (psel && !penable) begin
                        r_addr  <= paddr;
                        r_write <= pwrite;
                        r_wdata <= pwdata;
                        if (c_no_wait) begin
                            r_state <= S_READY;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_cnt_load;
                        end
                    end
                end
                S_WAIT: begin
                    if (!psel) begin
                        r_state <= S_IDLE;
                    end else if (w_go_ready) begin
                        r_state <= S_READY;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_READY: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .pclk    (pclk),
        .presetn (presetn),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
//============================================================================
// Module   : tb_apb_mem_slave
// Summary  : Directed self-checking bench for apb_mem_slave with one and
//            zero wait states.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apb_mem_slave;

    logic        pclk    = 1'b0;
    logic        presetn = 1'b1;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [31:0] prdata  [2];

    // Transaction-level model: memory image plus what each output must show this cycle.
    logic [31:0] m_mem     [2][64];
    logic [31:0] e_prdata  [2];
    logic        e_pready  [2];
    logic        e_pslverr [2];
    int          wait_of   [2] = '{1, 0};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_hi1 = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(1)) u_dut_w1 (
        .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0])
    );

    apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
        .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1])
    );

    always @(posedge pclk) cyc++;

    always @(negedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (pready[d] !== e_pready[d] || pslverr[d] !== e_pslverr[d] ||
                prdata[d] !== e_prdata[d]) begin
                n_err++;
                $display("FAIL cycle dut%0d t=%0t: pready/pslverr/prdata=%b/%b/%h required %b/%b/%h",
                         d, $time, pready[d], pslverr[d], prdata[d],
                         e_pready[d], e_pslverr[d], e_prdata[d]);
            end
        end
        if (pready[1] === 1'b1) n_hi1++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int d);
        step();
        psel[d]      = 1'b0;
        penable[d]   = 1'b0;
        e_pready[d]  = 1'b0;
        e_pslverr[d] = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) m_mem[d][i] = '0;
            e_prdata[d]  = '0;
            e_pready[d]  = 1'b0;
            e_pslverr[d] = 1'b0;
        end
    endtask

    // Full transfer: setup, wait_of[d] access cycles, then the completing cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic err;
        int   idx;
        err = (a[1:0] != 2'b00) || (a >= 32'd256);
        idx = int'(a[7:2]);
        step();
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        e_pready[d] = 1'b0; e_pslverr[d] = 1'b0;
        for (int k = 0; k < wait_of[d]; k++) begin
            step();
            penable[d] = 1'b1;
        end
        step();
        penable[d]   = 1'b1;
        e_pready[d]  = 1'b1;
        e_pslverr[d] = err;
        if (!wr)       e_prdata[d]   = err ? 32'd0 : m_mem[d][idx];
        else if (!err) m_mem[d][idx] = wd;
    endtask

    initial begin
        int c0;
        int h0;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0;  pwdata[d] = '0;
        end
        model_reset();
        #1 presetn = 1'b0;
        repeat (3) step();
        chk("reset_pready",  {31'b0, pready[0]},  32'd0);
        chk("reset_prdata",  prdata[0],           32'd0);
        chk("reset_pslverr", {31'b0, pslverr[1]}, 32'd0);
        step();
        presetn = 1'b1;
        idle(0);
        idle(1);

        // One wait state: write then read back
        c0 = cyc;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
        chk("wr_cycles", 32'(cyc - c0), 32'd3);
        xfer(0, 1'b0, 32'h10, 32'h0);
        chk("rd_0x10", prdata[0], 32'hDEADBEEF);
        chk("rd_0x10_err", {31'b0, pslverr[0]}, 32'd0);
        idle(0);

        // Out-of-range read and write (0x104 aliases word 1 if the check is missing)
        xfer(0, 1'b0, 32'h104, 32'h0);
        chk("oob_pslverr", {31'b0, pslverr[0]}, 32'd1);
        chk("oob_prdata",  prdata[0],           32'd0);
        xfer(0, 1'b1, 32'h104, 32'hCAFEF00D);
        xfer(0, 1'b0, 32'h4, 32'h0);
        chk("oob_no_alias", prdata[0], 32'd0);

        // Misaligned write must not disturb word 1
        xfer(0, 1'b1, 32'h4, 32'h11112222);
        xfer(0, 1'b1, 32'h6, 32'hBADBAD00);
        chk("misalign_err", {31'b0, pslverr[0]}, 32'd1);
        xfer(0, 1'b0, 32'h4, 32'h0);
        chk("misalign_keep", prdata[0], 32'h11112222);

        // penable without a preceding setup is ignored
        step(); psel[0] = 1'b1; penable[0] = 1'b1; e_pready[0] = 1'b0; e_pslverr[0] = 1'b0;
        step();
        idle(0);

        // Abort during WAIT
        xfer(0, 1'b1, 32'h20, 32'hA5A5A5A5);
        step(); psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h20; pwdata[0] = 32'h55; e_pready[0] = 1'b0; e_pslverr[0] = 1'b0;
        idle(0);
        idle(0);
        xfer(0, 1'b0, 32'h20, 32'h0);
        chk("abort_keep", prdata[0], 32'hA5A5A5A5);
        idle(0);

        // Zero wait states, back-to-back writes
        c0 = cyc;
        h0 = n_hi1;
        xfer(1, 1'b1, 32'h0, 32'h00000001);
        xfer(1, 1'b1, 32'h4, 32'h00000002);
        xfer(1, 1'b1, 32'h8, 32'h00000003);
        chk("b2b_cycles", 32'(cyc - c0), 32'd6);
        idle(1);
        chk("b2b_ready_hi", 32'(n_hi1 - h0), 32'd3);
        xfer(1, 1'b0, 32'h0, 32'h0);
        chk("b2b_rd0", prdata[1], 32'h1);
        xfer(1, 1'b0, 32'h8, 32'h0);
        chk("b2b_rd8", prdata[1], 32'h3);
        xfer(1, 1'b0, 32'hFC, 32'h0);
        chk("w0_last_word", prdata[1], 32'h0);
        xfer(1, 1'b0, 32'h100, 32'h0);
        chk("w0_oob_err", {31'b0, pslverr[1]}, 32'd1);
        idle(1);

        // Reset pulse while a write is in READY
        step();
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h30; pwdata[0] = 32'h77;
        e_pready[0] = 1'b0; e_pslverr[0] = 1'b0;
        step(); penable[0] = 1'b1;
        step(); presetn = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        model_reset();
        #1;
        chk("rst_pready",  {31'b0, pready[0]}, 32'd0);
        chk("rst_prdata",  prdata[0],          32'd0);
        chk("rst_prdata1", prdata[1],          32'd0);
        step();
        step();
        presetn = 1'b1;
        idle(0);
        xfer(0, 1'b1, 32'h0, 32'h12345678);
        xfer(0, 1'b0, 32'h0, 32'h0);
        chk("post_rst_rd0", prdata[0], 32'h12345678);
        xfer(0, 1'b0, 32'h30, 32'h0);
        chk("post_rst_rd30", prdata[0], 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0);
        chk("post_rst_rd10", prdata[0], 32'h0);
        idle(0);
        idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter DATA_W, default 32, width of pwdata/prdata and of each memory word.
REQ-002 Parameter ADDR_W, default 32, width of paddr.
REQ-003 Parameter DEPTH, default 64, number of memory words (power of two).
REQ-004 Parameter WAIT_CYCLES, default 1, wait states inserted per transfer (0..15).
REQ-005 pclk  input  1  sole clock; all state updates on rising edge.
REQ-006 presetn  input  1  asynchronous, active-low reset.
REQ-007 psel  input  1  slave select from APB master.
REQ-008 penable  input  1  access-phase strobe.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  ADDR_W  byte address.
REQ-011 pwdata  input  DATA_W  write data.
REQ-012 pready  output  1  transfer completes this cycle.
REQ-013 prdata  output  DATA_W  read data, valid while pready=1 for a read.
REQ-014 pslverr  output  1  error response, valid only while pready=1.

Function
REQ-015 FSM states: IDLE, WAIT, READY; the state register updates on the rising edge of pclk.
REQ-016 IDLE: on psel=1 & penable=0 the FSM latches paddr, pwrite and pwdata and goes to WAIT if WAIT_CYCLES>0, else to READY; any other input keeps it in IDLE.
REQ-017 Entry to WAIT loads wait counter with WAIT_CYCLES-1; the counter decrements each cycle; WAIT goes to READY when the counter is 0 and psel=1 & penable=1.
REQ-018 pready is 1 only in READY, is decoded from registered state, and is never combinational from inputs.
REQ-019 READY always goes to IDLE at the next edge; a back-to-back setup phase is then sampled in IDLE.
REQ-020 Transfer length: WAIT_CYCLES=0 gives 2 cycles (setup + access); in general it is 2+WAIT_CYCLES cycles.
REQ-021 Word index is latched_paddr[log2(DEPTH)+1:2]; byte lanes are not supported.
REQ-022 Address error: latched_paddr[1:0]!=0 or latched_paddr >= DEPTH*4 sets pslverr=1 in READY.
REQ-023 Write: memory word is updated at the edge leaving READY only if latched pwrite=1 and no address error.
REQ-024 Read: prdata is registered with mem[index] on entry to READY if read & no error; it is loaded with 0 on entry to READY if read & error.
REQ-025 prdata holds its last value outside READY and during write transfers.
REQ-026 Abort: psel=0 while in WAIT or READY sends the FSM to IDLE, performs no memory write, and leaves prdata unchanged.
REQ-027 penable=1 observed in IDLE without a preceding setup is ignored; the FSM stays in IDLE.
REQ-028 pslverr=0 in every state other than READY.

Reset
REQ-029 While presetn=0: state=IDLE, wait counter=0, pready=0, pslverr=0, prdata=0, latched address/control/data=0.
REQ-030 All memory words are cleared to 0 on reset.
REQ-031 Reset asserted mid-transfer aborts the transfer immediately with no memory write; after reset release the FSM starts in IDLE.

Structure
REQ-032 Shared package apb_mem_pkg holds the state enum (IDLE/WAIT/READY) and the defaults for DEPTH, DATA_W and WAIT_CYCLES.
REQ-033 One sub-module, apb_mem_array, holds the storage with a synchronous write port, a read port, and async clear; the FSM, counter and error decode stay in apb_mem_slave.

Verification
REQ-034 Reset release, WAIT_CYCLES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer takes 3 cycles, pready high for 1 cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-035 Read 0x104 with DEPTH=64 -> pslverr=1 with pready, prdata=0; a write to 0x104 leaves all words unchanged.
REQ-036 Write to 0x06 (misaligned) -> pslverr=1; a follow-up read of 0x04 returns its previous value.
REQ-037 Back-to-back write 0x0/0x4/0x8 with WAIT_CYCLES=0 -> 6 cycles total, pready toggles 0,1,0,1,0,1; readback matches.
REQ-038 psel dropped during WAIT on a write of 0x55 to 0x20 -> FSM returns to IDLE, pready never rises, and mem[8] keeps its old value.
REQ-039 presetn pulsed low in READY of a write -> no write occurs; all outputs are 0; a read of any address returns 0.
